// File: rtl/counter_ud_param.sv
// counter_ud_param: up/down counter with tick generator, debounced direction and run buttons,
// synchronous load, programmable modulus and wrap/saturate limits.
module counter_ud_param #(
  parameter int WIDTH     = 8,
  parameter int CLK_HZ    = 50000000,
  parameter int TICK_HZ   = 1,
  parameter int DB_CYCLES = 1000000,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_ud,
  input  logic             btn_run,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             running,
  output logic             tick,
  output logic             tc
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int BW  = $clog2(DB_CYCLES);
  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   LIM     = (WIDTH+1)'(MAX_COUNT);
  localparam logic [DW-1:0]    DIV_END = DW'(DIV-1);
  localparam logic [DW-1:0]    DIV_PRE = DW'(DIV-2);
  localparam logic [BW-1:0]    DB_END  = BW'(DB_CYCLES-1);

  logic [1:0] raw, press;
  assign raw = {btn_run, btn_ud};

  genvar i;
  generate
    for (i = 0; i < 2; i++) begin : g_db
      logic s1, s2, stb;
      logic [BW-1:0] cnt;
      // press fires in the cycle the stable level is about to rise
      assign press[i] = s2 & ~stb & (cnt == DB_END);
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          s1  <= 1'b0;
          s2  <= 1'b0;
          stb <= 1'b0;
          cnt <= '0;
        end else begin
          s1 <= raw[i];
          s2 <= s1;
          if (s2 == stb) cnt <= '0;
          else if (cnt == DB_END) begin
            stb <= s2;
            cnt <= '0;
          end else cnt <= cnt + 1'b1;
        end
    end
  endgenerate

  logic          run_nx, at_lim, oor;
  logic [DW-1:0] div;
  logic [WIDTH-1:0] q_tick, q_load;

  assign run_nx = running ^ press[1];

  always_comb begin
    at_lim = dir ? (q == MAXV) : (q == '0);
    oor    = {1'b0, q} > LIM;
    q_load = ({1'b0, load_val} > LIM) ? MAXV : load_val;
    q_tick = oor ? '0 :
             at_lim ? ((SATURATE != 0) ? q : (dir ? '0 : MAXV)) :
             (dir ? q + 1'b1 : q - 1'b1);
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      q       <= '0;
      dir     <= 1'b1;
      running <= 1'b1;
      tick    <= 1'b0;
      tc      <= 1'b0;
      div     <= '0;
    end else begin
      dir     <= dir ^ press[0];
      running <= run_nx;
      // divider only advances while running before and after this edge, so a resume restarts from 0
      if (running && run_nx) begin
        div  <= (div == DIV_END) ? '0 : div + 1'b1;
        tick <= (div == DIV_PRE);
      end else begin
        div  <= '0;
        tick <= 1'b0;
      end
      tc <= !load && tick && at_lim;
      if (load) q <= q_load;
      else if (tick) q <= q_tick;
    end
endmodule

// File: tb/tb_counter_ud_param.sv
// tb_counter_ud_param: directed checks of a wrapping and a saturating counter (DIV=10, DB_CYCLES=4, MAX_COUNT=9).
module tb_counter_ud_param;
  logic clk = 1'b0, reset = 1'b0, btn_ud = 1'b0, btn_run = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] q0, q1;
  logic dir0, dir1, run0, run1, tick0, tick1, tc0, tc1;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  counter_ud_param #(.WIDTH(4), .CLK_HZ(10), .TICK_HZ(1), .DB_CYCLES(4), .MAX_COUNT(9), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .btn_ud(btn_ud), .btn_run(btn_run), .load(load), .load_val(load_val),
    .q(q0), .dir(dir0), .running(run0), .tick(tick0), .tc(tc0));

  counter_ud_param #(.WIDTH(4), .CLK_HZ(10), .TICK_HZ(1), .DB_CYCLES(4), .MAX_COUNT(9), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .btn_ud(btn_ud), .btn_run(btn_run), .load(load), .load_val(load_val),
    .q(q1), .dir(dir1), .running(run1), .tick(tick1), .tc(tc1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    cyc(3);
    check("rst_q", q0, 0);
    check("rst_dir", dir0, 1);
    check("rst_run", run0, 1);
    check("rst_tick", tick0, 0);
    check("rst_tc", tc0, 0);
    reset = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      cyc(1);
      check("t1_q", q0, (k / 10) % 10);
      check("t1_tick", tick0, k % 10 == 9);
      check("t1_tc", tc0, k == 100);
    end
    // direction press at q=3
    cyc(30);
    check("t2_q3", q0, 3);
    btn_ud = 1'b1;
    cyc(5);
    check("t2_dir_early", dir0, 1);
    cyc(1);
    check("t2_dir_late", dir0, 0);
    cyc(4);
    btn_ud = 1'b0;
    check("t2_q2", q0, 2);
    cyc(10);
    check("t2_q1", q0, 1);
    cyc(10);
    check("t2_q0", q0, 0);
    check("t2_tc_q0", tc0, 0);
    cyc(10);
    check("t2_q9", q0, 9);
    check("t2_tc", tc0, 1);
    cyc(1);
    check("t2_tc_end", tc0, 0);
    btn_ud = 1'b1;
    cyc(2);
    btn_ud = 1'b0;
    cyc(10);
    check("t2_glitch_dir", dir0, 0);
    check("t2_q8", q0, 8);
    // back to up, then load during tick cycles
    btn_ud = 1'b1;
    cyc(6);
    check("t4_dir_up", dir0, 1);
    check("t4_tick", tick0, 1);
    check("t4_q8", q0, 8);
    btn_ud = 1'b0;
    load = 1'b1;
    load_val = 4'd15;
    cyc(1);
    load = 1'b0;
    check("t4_clamp", q0, 9);
    check("t4_clamp_tc", tc0, 0);
    cyc(9);
    check("t4_tick2", tick0, 1);
    check("t4_q9", q0, 9);
    load = 1'b1;
    load_val = 4'd5;
    cyc(1);
    load = 1'b0;
    check("t4_load5", q0, 5);
    check("t4_load_tc", tc0, 0);
    cyc(10);
    check("t4_q6", q0, 6);
    // pause, load while paused, resume
    btn_run = 1'b1;
    cyc(5);
    check("t5_run_early", run0, 1);
    cyc(1);
    check("t5_paused", run0, 0);
    btn_run = 1'b0;
    for (int j = 0; j < 20; j++) begin
      cyc(1);
      check("t5_no_tick", tick0, 0);
      check("t5_frozen", q0, 6);
    end
    load = 1'b1;
    load_val = 4'd2;
    cyc(1);
    load = 1'b0;
    check("t5_load_paused", q0, 2);
    btn_run = 1'b1;
    cyc(5);
    check("t5_still_paused", run0, 0);
    cyc(1);
    check("t5_resumed", run0, 1);
    btn_run = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      cyc(1);
      check("t5_wait_tick", tick0, 0);
    end
    cyc(1);
    check("t5_first_tick", tick0, 1);
    cyc(1);
    check("t5_q3", q0, 3);
    // asynchronous reset at q=7, dir=0
    load = 1'b1;
    load_val = 4'd7;
    cyc(1);
    load = 1'b0;
    check("t6_q7", q0, 7);
    btn_ud = 1'b1;
    cyc(6);
    check("t6_dir_down", dir0, 0);
    check("t6_q7_hold", q0, 7);
    btn_ud = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("t6_async_q", q0, 0);
    check("t6_async_dir", dir0, 1);
    check("t6_async_run", run0, 1);
    check("t6_async_tick", tick0, 0);
    check("t6_async_tc", tc0, 0);
    cyc(2);
    reset = 1'b1;
    for (int r = 1; r <= 9; r++) begin
      cyc(1);
      check("t6_tick", tick0, r == 9);
      check("t6_q0", q0, 0);
    end
    cyc(1);
    check("t6_resume_q1", q0, 1);
    // saturate instance
    load = 1'b1;
    load_val = 4'd7;
    cyc(1);
    load = 1'b0;
    check("t3_q7", q1, 7);
    cyc(9);
    check("t3_q8", q1, 8);
    cyc(10);
    check("t3_q9", q1, 9);
    check("t3_tc_q9", tc1, 0);
    cyc(10);
    check("t3_hold9", q1, 9);
    check("t3_tc1", tc1, 1);
    check("t3_wrap_q0", q0, 0);
    check("t3_wrap_tc", tc0, 1);
    cyc(1);
    check("t3_tc1_end", tc1, 0);
    cyc(9);
    check("t3_hold9b", q1, 9);
    check("t3_tc2", tc1, 1);
    load = 1'b1;
    load_val = 4'd0;
    cyc(1);
    load = 1'b0;
    check("t3_load0", q1, 0);
    btn_ud = 1'b1;
    cyc(6);
    check("t3_dir_down", dir1, 0);
    btn_ud = 1'b0;
    cyc(3);
    check("t3_hold0", q1, 0);
    check("t3_tc_down", tc1, 1);
    check("t3_wrap_down", q0, 9);
    cyc(10);
    check("t3_hold0b", q1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
